param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter with load, programmable step and window limits [lo_lim, hi_lim],
//   and selectable wrap or saturate at the limits.
//   Terminal-count pulse and sticky overflow/underflow flags.
//   Next generation of the fixed 16-bit up/down counter.
//   Drives timers, address generators and event counters.
// PARAMETERS
//   W        16  counter, step, limit and load width (bits, >=2)
//   PRE_W    8   prescaler divider width (used only when PUDC_PRESCALE_EN is defined)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   reset      in   1      synchronous, active-high reset
//   en         in   1      count enable
//   load       in   1      synchronous load of load_val
//   load_val   in   W      value loaded when load=1
//   up_down    in   1      1 = count up, 0 = count down
//   step       in   W      increment/decrement magnitude per advance
//   lo_lim     in   W      lower window limit (inclusive)
//   hi_lim     in   W      upper window limit (inclusive)
//   sat_mode   in   1      1 = saturate at limit, 0 = wrap to opposite limit
//   clr_flags  in   1      clears ovf_flag/udf_flag
//   count      out  W      registered count value
//   tc         out  1      one-cycle pulse, registered, on any limit crossing
//   ovf_flag   out  1      sticky: up-count crossed hi_lim
//   udf_flag   out  1      sticky: down-count crossed lo_lim
//   cfg_err    out  1      combinational: lo_lim > hi_lim
// BEHAVIOUR
//   - Reset values (reset=1 at clk edge): count=0, tc=0, ovf_flag=0, udf_flag=0, prescaler=0.
//   - Priority: reset > load > advance.
//   - load=1 sets count=load_val next cycle regardless of en/limits, and clears the prescaler.
//   - load sets tc=0.
//   - Advance: en=1, load=0 and cfg_err=0 (and prescaler terminal if enabled).
//   - When cfg_err=1 the count holds, tc=0, flags hold; load is still honoured.
//   - Up: sum = {1'b0,count}+step in W+1 bits.
//     - sum > hi_lim (including carry): crossing.
//     - Crossing result: count = sat_mode ? hi_lim : lo_lim; tc=1; ovf_flag set.
//     - Otherwise count = sum[W-1:0].
//   - Down: crossing if count < step or count-step < lo_lim.
//     - Crossing result: count = sat_mode ? lo_lim : hi_lim; tc=1; udf_flag set.
//     - Otherwise count = count-step.
//   - Saturated at hi_lim while still counting up: each further advance re-asserts tc and keeps ovf set.
//     The same applies at lo_lim while counting down.
//   - step=0: count holds, no crossing, tc=0.
//   - A loaded count outside the window is kept; the next advance beyond the limit counts as a crossing.
//   - tc is 0 in every cycle without a crossing. Latency: count/tc valid 1 cycle after the qualifying edge.
//   - clr_flags with a simultaneous new crossing: the crossing wins (flag stays 1).
//   - Limit or mode changes take effect on the next advance. Reset mid-count returns to 0 within 1 cycle.
// CONFIGURATION
//   PUDC_PRESCALE_EN defined:
//     - Adds input pre_div[PRE_W-1:0] and an internal PRE_W-bit prescaler.
//     - With en=1 the prescaler increments each cycle; the advance occurs when prescaler==pre_div,
//       after which the prescaler returns to 0.
//     - pre_div=0 advances every enabled cycle.
//     - en=0 freezes the prescaler.
//   PUDC_PRESCALE_EN undefined: no pre_div port and no prescaler; advance every cycle with en=1.
// TESTING
//   - Reset: assert reset 2 cycles mid-count at count=0x1234 -> count=0, tc=0, ovf=udf=0 next cycle.
//   - Up wrap: lo=2, hi=10, step=3, sat=0, load 8 then count up ->
//     - 8 -> 2 with tc=1 and ovf=1.
//     - next values 5, 8, 2.
//   - Down saturate: lo=4, hi=20, step=5, sat=1, load 6 then count down ->
//     - 6 -> 4 with tc=1 and udf=1.
//     - stays 4 with tc=1 each cycle.
//   - Full-range carry: lo=0, hi=0xFFFF, step=1, count=0xFFFF, up ->
//     - wrap gives 0, tc=1.
//     - with sat=1 it holds at 0xFFFF.
//   - Priority and flags:
//     - load=1, en=1 on the same edge -> load_val taken, tc=0.
//     - clr_flags with a simultaneous overflow -> ovf=1.
//     - lo=9, hi=3 -> cfg_err=1 and count frozen.
//   - Prescale (macro on): pre_div=2, step=1, up from 0 -> count increments every 3rd enabled cycle;
//     en low for 4 cycles adds no advance.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// PUDC_PRESCALE_EN adds the PRE_W parameter and the pre_div signal.
interface param_updown_counter_if #(
  parameter int unsigned W = 16
`ifdef PUDC_PRESCALE_EN
  , parameter int unsigned PRE_W = 8
`endif
);

  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         up_down;
  logic [W-1:0] step;
  logic [W-1:0] lo_lim;
  logic [W-1:0] hi_lim;
  logic         sat_mode;
  logic         clr_flags;
`ifdef PUDC_PRESCALE_EN
  logic [PRE_W-1:0] pre_div;
`endif
  logic [W-1:0] count;
  logic         tc;
  logic         ovf_flag;
  logic         udf_flag;
  logic         cfg_err;

  modport master (
    output en, load, load_val, up_down, step, lo_lim, hi_lim, sat_mode, clr_flags,
`ifdef PUDC_PRESCALE_EN
    output pre_div,
`endif
    input  count, tc, ovf_flag, udf_flag, cfg_err
  );

  modport slave (
    input  en, load, load_val, up_down, step, lo_lim, hi_lim, sat_mode, clr_flags,
`ifdef PUDC_PRESCALE_EN
    input  pre_div,
`endif
    output count, tc, ovf_flag, udf_flag, cfg_err
  );

endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter with load, programmable step, [lo_lim, hi_lim] window and wrap/saturate.
// Optional prescaler enabled by defining PUDC_PRESCALE_EN.
module param_updown_counter #(
  parameter int unsigned W     = 16,
  parameter int unsigned PRE_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  param_updown_counter_if.slave bus
);

  if (W < 2) begin : g_bad_w
    $error("param_updown_counter: W must be >= 2");
  end
  if (PRE_W < 1) begin : g_bad_pre_w
    $error("param_updown_counter: PRE_W must be >= 1");
  end

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;

  logic         cfg_err;
  logic         tick;
  logic         advance;
  logic         step_nz;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic         up_cross;
  logic         dn_cross;

  assign cfg_err = (bus.lo_lim > bus.hi_lim);

`ifdef PUDC_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = (pre_q == bus.pre_div);

  // Prescaler runs on en alone; load restarts the division period.
  always_comb begin
    pre_d = pre_q;
    if (bus.load) begin
      pre_d = '0;
    end else if (bus.en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign advance = bus.en & ~bus.load & ~cfg_err & tick;

  // Extra carry bit lets an up-count past the top of the range register as a crossing.
  assign sum     = {1'b0, count_q} + {1'b0, bus.step};
  assign diff    = count_q - bus.step;
  assign step_nz = |bus.step;

  assign up_cross = step_nz & (sum > {1'b0, bus.hi_lim});
  assign dn_cross = step_nz & ((count_q < bus.step) | (diff < bus.lo_lim));

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_flags;
    udf_d   = udf_q & ~bus.clr_flags;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (advance) begin
      if (bus.up_down) begin
        if (up_cross) begin
          count_d = bus.sat_mode ? bus.hi_lim : bus.lo_lim;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = sum[W-1:0];
        end
      end else begin
        if (dn_cross) begin
          count_d = bus.sat_mode ? bus.lo_lim : bus.hi_lim;
          tc_d    = 1'b1;
          udf_d   = 1'b1;
        end else begin
          count_d = diff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.ovf_flag = ovf_q;
  assign bus.udf_flag = udf_q;
  assign bus.cfg_err  = cfg_err;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter with an expectation queue.
// Covers the prescaler when compiled with PUDC_PRESCALE_EN.
module tb_param_updown_counter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

`ifdef PUDC_PRESCALE_EN
  param_updown_counter_if #(.W(16), .PRE_W(8)) bus_if ();
  param_updown_counter #(.W(16), .PRE_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );
`else
  param_updown_counter_if #(.W(16)) bus_if ();
  param_updown_counter #(.W(16), .PRE_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );
`endif

  typedef struct {
    logic [15:0] count;
    logic        tc;
    logic        ovf;
    logic        udf;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".count"}, {16'h0, bus_if.count}, {16'h0, e.count});
      chk({e.tag, ".tc"},    {31'h0, bus_if.tc},       {31'h0, e.tc});
      chk({e.tag, ".ovf"},   {31'h0, bus_if.ovf_flag}, {31'h0, e.ovf});
      chk({e.tag, ".udf"},   {31'h0, bus_if.udf_flag}, {31'h0, e.udf});
    end
  endtask

  // Inputs are already driven; queue the expected post-edge state, clock once, compare.
  task automatic cyc(input string tag, input logic [15:0] c, input logic t, input logic o,
                     input logic u);
    exp_t e;
    e.count = c;
    e.tc    = t;
    e.ovf   = o;
    e.udf   = u;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic set_cfg(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] stp,
                         input logic up, input logic sat);
    bus_if.lo_lim   = lo;
    bus_if.hi_lim   = hi;
    bus_if.step     = stp;
    bus_if.up_down  = up;
    bus_if.sat_mode = sat;
  endtask

  initial begin
    reset            = 1'b1;
    bus_if.en        = 1'b0;
    bus_if.load      = 1'b0;
    bus_if.load_val  = 16'h0;
    bus_if.clr_flags = 1'b0;
`ifdef PUDC_PRESCALE_EN
    bus_if.pre_div   = 8'd0;
`endif
    set_cfg(16'h0, 16'hFFFF, 16'h1, 1'b1, 1'b0);
    cyc("reset", 16'h0, 1'b0, 1'b0, 1'b0);

    // Full-range carry: wrap, then saturate
    reset           = 1'b0;
    bus_if.load     = 1'b1;
    bus_if.load_val = 16'hFFFF;
    cyc("load_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    bus_if.load = 1'b0;
    bus_if.en   = 1'b1;
    cyc("full_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    bus_if.load = 1'b1;
    cyc("load_over_en", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    bus_if.load     = 1'b0;
    bus_if.sat_mode = 1'b1;
    cyc("full_sat", 16'hFFFF, 1'b1, 1'b1, 1'b0);
    cyc("full_sat2", 16'hFFFF, 1'b1, 1'b1, 1'b0);

    // Count to 0x1234, then reset mid-count for 2 cycles
    bus_if.load     = 1'b1;
    bus_if.load_val = 16'h1232;
    cyc("load_1232", 16'h1232, 1'b0, 1'b1, 1'b0);
    bus_if.load     = 1'b0;
    bus_if.sat_mode = 1'b0;
    cyc("cnt_1233", 16'h1233, 1'b0, 1'b1, 1'b0);
    cyc("cnt_1234", 16'h1234, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc("reset_mid1", 16'h0, 1'b0, 1'b0, 1'b0);
    cyc("reset_mid2", 16'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Up wrap in [2,10], step 3
    set_cfg(16'd2, 16'd10, 16'd3, 1'b1, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.load_val = 16'd8;
    cyc("wrap_load", 16'd8, 1'b0, 1'b0, 1'b0);
    bus_if.load = 1'b0;
    cyc("wrap_cross", 16'd2, 1'b1, 1'b1, 1'b0);
    cyc("wrap_5", 16'd5, 1'b0, 1'b1, 1'b0);
    cyc("wrap_8", 16'd8, 1'b0, 1'b1, 1'b0);
    cyc("wrap_2", 16'd2, 1'b1, 1'b1, 1'b0);
    cyc("wrap_5b", 16'd5, 1'b0, 1'b1, 1'b0);
    cyc("wrap_8b", 16'd8, 1'b0, 1'b1, 1'b0);
    bus_if.clr_flags = 1'b1;
    cyc("clr_vs_ovf", 16'd2, 1'b1, 1'b1, 1'b0);
    cyc("clr_flags", 16'd5, 1'b0, 1'b0, 1'b0);
    bus_if.clr_flags = 1'b0;

    // Down saturate in [4,20], step 5
    set_cfg(16'd4, 16'd20, 16'd5, 1'b0, 1'b1);
    bus_if.load     = 1'b1;
    bus_if.load_val = 16'd6;
    cyc("dsat_load", 16'd6, 1'b0, 1'b0, 1'b0);
    bus_if.load = 1'b0;
    cyc("dsat_cross", 16'd4, 1'b1, 1'b0, 1'b1);
    cyc("dsat_hold1", 16'd4, 1'b1, 1'b0, 1'b1);
    cyc("dsat_hold2", 16'd4, 1'b1, 1'b0, 1'b1);
    bus_if.step = 16'd0;
    cyc("step0", 16'd4, 1'b0, 1'b0, 1'b1);

    // Inverted window freezes the count but load still works
    set_cfg(16'd9, 16'd3, 16'd1, 1'b1, 1'b0);
    #1;
    chk("cfg_err_set", {31'h0, bus_if.cfg_err}, 32'd1);
    cyc("cfg_frozen", 16'd4, 1'b0, 1'b0, 1'b1);
    bus_if.load     = 1'b1;
    bus_if.load_val = 16'd7;
    cyc("cfg_load", 16'd7, 1'b0, 1'b0, 1'b1);
    bus_if.load = 1'b0;
    cyc("cfg_frozen2", 16'd7, 1'b0, 1'b0, 1'b1);

    // Loaded value above the window crosses on the next advance
    set_cfg(16'd2, 16'd10, 16'd1, 1'b1, 1'b0);
    #1;
    chk("cfg_err_clr", {31'h0, bus_if.cfg_err}, 32'd0);
    bus_if.load     = 1'b1;
    bus_if.load_val = 16'd15;
    cyc("out_load", 16'd15, 1'b0, 1'b0, 1'b1);
    bus_if.load = 1'b0;
    cyc("out_cross", 16'd2, 1'b1, 1'b1, 1'b1);

`ifdef PUDC_PRESCALE_EN
    // Divide by 3; en low freezes the prescaler
    set_cfg(16'd0, 16'hFFFF, 16'd1, 1'b1, 1'b0);
    bus_if.pre_div   = 8'd2;
    bus_if.load      = 1'b1;
    bus_if.load_val  = 16'd0;
    bus_if.clr_flags = 1'b1;
    cyc("pre_load", 16'd0, 1'b0, 1'b0, 1'b0);
    bus_if.load      = 1'b0;
    bus_if.clr_flags = 1'b0;
    cyc("pre_c1", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc("pre_c2", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc("pre_c3", 16'd1, 1'b0, 1'b0, 1'b0);
    cyc("pre_c4", 16'd1, 1'b0, 1'b0, 1'b0);
    cyc("pre_c5", 16'd1, 1'b0, 1'b0, 1'b0);
    cyc("pre_c6", 16'd2, 1'b0, 1'b0, 1'b0);
    bus_if.en = 1'b0;
    for (int i = 0; i < 4; i++) cyc("pre_idle", 16'd2, 1'b0, 1'b0, 1'b0);
    bus_if.en = 1'b1;
    cyc("pre_c7", 16'd2, 1'b0, 1'b0, 1'b0);
    cyc("pre_c8", 16'd2, 1'b0, 1'b0, 1'b0);
    cyc("pre_c9", 16'd3, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
